// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multi-cycle fetch/decode/execute/memory control sequencer (optional CTRL_PERF_CNT_EN perf counters)
module control_sequencer #(
    parameter int OPW = 4,
    parameter int TMO = 15,
    parameter int TMW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPW-1:0]    opcode,
    input  logic              mem_ready,
    input  logic              alu_eq,
    input  logic              alu_lt,
    output logic              mem_req,
    output logic              mem_we,
    output logic              addr_sel,
    output logic              ir_load,
    output logic              pc_inc,
    output logic              pc_load,
    output logic              rf_we,
    output logic [2:0]        alu_op,
    output logic [2**OPW-1:0] dec,
    output logic              ir_valid,
    output logic              bus_err,
    output logic              illegal_op,
    output logic [2:0]        state
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]       retired,
    output logic [31:0]       stall_cyc
`endif
);

    localparam int DW = 2**OPW;

    typedef enum logic [2:0] {
        FETCH0 = 3'd0,
        FETCH1 = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_ADDI = 4'd3;
    localparam logic [3:0] OP_ANDI = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_NAND = 4'd6;
    localparam logic [3:0] OP_JMP  = 4'd7;
    localparam logic [3:0] OP_LD   = 4'd8;
    localparam logic [3:0] OP_ST   = 4'd9;
    localparam logic [3:0] OP_CMP  = 4'd10;
    localparam logic [3:0] OP_JE   = 4'd11;
    localparam logic [3:0] OP_JA   = 4'd12;
    localparam logic [3:0] OP_JB   = 4'd13;
    localparam logic [3:0] OP_JAE  = 4'd14;
    localparam logic [3:0] OP_JBE  = 4'd15;

    localparam logic [TMW-1:0] TMO_LAST = TMW'(TMO - 1);

    state_t          st;
    logic [3:0]      op_q;
    logic            eq_q;
    logic            lt_q;
    logic [TMW-1:0]  cnt;
    logic            rf_we_q;
    logic [2:0]      alu_op_q;
    logic [31:0]     op_ext;
    logic            op_illegal;
    logic [3:0]      op_lo;
    logic [DW-1:0]   one_hot;
    logic            ld_wb;

    assign op_ext     = 32'(opcode);
    assign op_illegal = (op_ext < 32'd2) || (op_ext > 32'd15);
    assign op_lo      = opcode[3:0];
    assign one_hot    = {{(DW-1){1'b0}}, 1'b1} << opcode;

    // Load write-back must coincide with the data beat, so it is the one
    // strobe that follows mem_ready combinationally.
    assign ld_wb  = (st == MEM) && mem_ready && (op_q == OP_LD);
    assign rf_we  = rf_we_q | ld_wb;
    assign alu_op = ld_wb ? 3'd7 : alu_op_q;
    assign state  = st;

    function automatic logic branch_taken(input logic [3:0] op, input logic eq, input logic lt);
        case (op)
            OP_JE:   return eq;
            OP_JA:   return !eq && !lt;
            OP_JB:   return lt;
            OP_JAE:  return !lt;
            OP_JBE:  return eq || lt;
            default: return 1'b0;
        endcase
    endfunction

    // Sequencer: outputs are registered for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= FETCH0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            addr_sel   <= 1'b0;
            ir_load    <= 1'b0;
            pc_inc     <= 1'b0;
            pc_load    <= 1'b0;
            rf_we_q    <= 1'b0;
            alu_op_q   <= 3'd0;
            dec        <= '0;
            ir_valid   <= 1'b0;
            bus_err    <= 1'b0;
            illegal_op <= 1'b0;
            op_q       <= 4'd0;
            eq_q       <= 1'b0;
            lt_q       <= 1'b0;
            cnt        <= '0;
        end else begin
            ir_load    <= 1'b0;
            pc_inc     <= 1'b0;
            pc_load    <= 1'b0;
            rf_we_q    <= 1'b0;
            alu_op_q   <= 3'd0;
            illegal_op <= 1'b0;
            cnt        <= '0;
            case (st)
                FETCH0: begin
                    // A fetch completes only against a request already on the bus.
                    if (mem_req && mem_ready) begin
                        st      <= FETCH1;
                        mem_req <= 1'b0;
                        ir_load <= 1'b1;
                        pc_inc  <= 1'b1;
                    end else begin
                        mem_req  <= 1'b1;
                        addr_sel <= 1'b0;
                    end
                end
                FETCH1: begin
                    st       <= DECODE;
                    ir_valid <= 1'b1;
                end
                DECODE: begin
                    op_q <= op_lo;
                    if (op_illegal) begin
                        dec        <= '0;
                        illegal_op <= 1'b1;
                        st         <= FETCH0;
                        mem_req    <= 1'b1;
                        addr_sel   <= 1'b0;
                        ir_valid   <= 1'b0;
                    end else begin
                        dec <= one_hot;
                        st  <= EXEC;
                        case (op_lo)
                            OP_ADD:  begin rf_we_q <= 1'b1; alu_op_q <= 3'd0; end
                            OP_ADDI: begin rf_we_q <= 1'b1; alu_op_q <= 3'd2; end
                            OP_ANDI: begin rf_we_q <= 1'b1; alu_op_q <= 3'd3; end
                            OP_OR:   begin rf_we_q <= 1'b1; alu_op_q <= 3'd4; end
                            OP_NAND: begin rf_we_q <= 1'b1; alu_op_q <= 3'd5; end
                            OP_JMP:  pc_load <= 1'b1;
                            default: pc_load <= branch_taken(op_lo, eq_q, lt_q);
                        endcase
                    end
                end
                EXEC: begin
                    if (op_q == OP_CMP) begin
                        eq_q <= alu_eq;
                        lt_q <= alu_lt;
                    end
                    mem_req <= 1'b1;
                    if (op_q == OP_LD || op_q == OP_ST) begin
                        st       <= MEM;
                        addr_sel <= 1'b1;
                        mem_we   <= (op_q == OP_ST);
                    end else begin
                        st       <= FETCH0;
                        addr_sel <= 1'b0;
                        ir_valid <= 1'b0;
                    end
                end
                MEM: begin
                    // Ready on the final counted cycle still wins over the timeout.
                    if (mem_ready) begin
                        st       <= FETCH0;
                        addr_sel <= 1'b0;
                        mem_we   <= 1'b0;
                        ir_valid <= 1'b0;
                    end else if (cnt == TMO_LAST) begin
                        st       <= HALT;
                        bus_err  <= 1'b1;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        addr_sel <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    mem_req  <= 1'b0;
                    mem_we   <= 1'b0;
                    addr_sel <= 1'b0;
                end
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    // Retirement and memory-stall counters; HALT never matches either term.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired   <= 32'd0;
            stall_cyc <= 32'd0;
        end else begin
            if (st == EXEC || (st == MEM && mem_ready)) begin
                retired <= retired + 32'd1;
            end
            if ((st == FETCH0 || st == MEM) && !mem_ready) begin
                stall_cyc <= stall_cyc + 32'd1;
            end
        end
    end
`endif

endmodule
